// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_transceiver
//
// Self-contained 8N1 UART: one oversampling tick generator shared by an
// independent transmitter and receiver.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset
//   tick_out      oversample tick, one clock wide, every DIV clocks
//   tx_data_in    byte to transmit, latched when a frame is accepted
//   tx_enable_in  start-transmit strobe, ignored while busy
//   tx_out        serial TX line, idle high
//   tx_busy_out   high while a TX frame is in progress
//   tx_done_out   one-clock pulse at the end of the TX stop bit
//   rx_in         asynchronous serial RX line
//   rx_enable_in  allows the receiver to start a new frame
//   rx_data_out   last correctly framed byte
//   rx_done_out   one-clock pulse when rx_data_out updates
// -----------------------------------------------------------------------------
module uart_transceiver #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUDRATE_HZ = 115_200,
  parameter int SAMPLE_RATE = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic       tick_out,
  input  logic [7:0] tx_data_in,
  input  logic       tx_enable_in,
  output logic       tx_out,
  output logic       tx_busy_out,
  output logic       tx_done_out,
  input  logic       rx_in,
  input  logic       rx_enable_in,
  output logic [7:0] rx_data_out,
  output logic       rx_done_out
);

  localparam int DIV_RAW = CLK_HZ / (BAUDRATE_HZ * SAMPLE_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W  = $clog2(SAMPLE_RATE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(SAMPLE_RATE - 1);
  localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(SAMPLE_RATE / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rxState_t;

  // ---------------------------------------------------------------------------
  // Tick generator: free-running divider, tick registered on wrap
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_divCnt;
  logic             r_tick;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_divCnt <= '0;
      r_tick   <= 1'b0;
    end else if (r_divCnt == DIV_LAST) begin
      r_divCnt <= '0;
      r_tick   <= 1'b1;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
      r_tick   <= 1'b0;
    end
  end

  assign tick_out = r_tick;

  // ---------------------------------------------------------------------------
  // Transmitter. Outputs are registered from next-state values so the pin
  // never glitches on state decoding. The start bit is driven low on entry
  // and ends on the SAMPLE_RATE-th tick, so it may be up to one tick short.
  // ---------------------------------------------------------------------------
  txState_t          r_txState, w_txStateNext;
  logic [TCNT_W-1:0] r_txTickCnt, w_txTickCntNext;
  logic [2:0]        r_txBitIdx, w_txBitIdxNext;
  logic [7:0]        r_txShift, w_txShiftNext;
  logic              r_txOut, w_txOutNext;
  logic              r_txBusy, w_txBusyNext;
  logic              r_txDone, w_txDoneNext;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_txState   <= TX_IDLE;
      r_txTickCnt <= '0;
      r_txBitIdx  <= '0;
      r_txShift   <= '0;
      r_txOut     <= 1'b1;
      r_txBusy    <= 1'b0;
      r_txDone    <= 1'b0;
    end else begin
      r_txState   <= w_txStateNext;
      r_txTickCnt <= w_txTickCntNext;
      r_txBitIdx  <= w_txBitIdxNext;
      r_txShift   <= w_txShiftNext;
      r_txOut     <= w_txOutNext;
      r_txBusy    <= w_txBusyNext;
      r_txDone    <= w_txDoneNext;
    end
  end

  always_comb begin
    w_txStateNext   = r_txState;
    w_txTickCntNext = r_txTickCnt;
    w_txBitIdxNext  = r_txBitIdx;
    w_txShiftNext   = r_txShift;
    w_txOutNext     = r_txOut;
    w_txBusyNext    = r_txBusy;
    w_txDoneNext    = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        w_txOutNext  = 1'b1;
        w_txBusyNext = 1'b0;
        if (tx_enable_in) begin
          w_txStateNext   = TX_START;
          w_txShiftNext   = tx_data_in;
          w_txTickCntNext = '0;
          w_txBitIdxNext  = '0;
          w_txOutNext     = 1'b0;
          w_txBusyNext    = 1'b1;
        end
      end
      TX_START: begin
        if (r_tick) begin
          if (r_txTickCnt == BIT_LAST) begin
            w_txTickCntNext = '0;
            w_txStateNext   = TX_DATA;
            w_txOutNext     = r_txShift[0];
          end else begin
            w_txTickCntNext = r_txTickCnt + TCNT_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (r_tick) begin
          if (r_txTickCnt == BIT_LAST) begin
            w_txTickCntNext = '0;
            if (r_txBitIdx == 3'd7) begin
              w_txStateNext = TX_STOP;
              w_txOutNext   = 1'b1;
            end else begin
              // Shift right so the next data bit is always at bit 0
              w_txBitIdxNext = r_txBitIdx + 3'd1;
              w_txShiftNext  = {1'b0, r_txShift[7:1]};
              w_txOutNext    = r_txShift[1];
            end
          end else begin
            w_txTickCntNext = r_txTickCnt + TCNT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (r_tick) begin
          if (r_txTickCnt == BIT_LAST) begin
            w_txTickCntNext = '0;
            w_txStateNext   = TX_IDLE;
            w_txDoneNext    = 1'b1;
            w_txBusyNext    = 1'b0;
          end else begin
            w_txTickCntNext = r_txTickCnt + TCNT_W'(1);
          end
        end
      end
      default: begin
        w_txStateNext = TX_IDLE;
      end
    endcase
  end

  assign tx_out      = r_txOut;
  assign tx_busy_out = r_txBusy;
  assign tx_done_out = r_txDone;

  // ---------------------------------------------------------------------------
  // Receiver front end: two-flop synchroniser, idles high like the line
  // ---------------------------------------------------------------------------
  logic r_rxSync1;
  logic r_rxSync2;
  logic w_rxLine;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
    end else begin
      r_rxSync1 <= rx_in;
      r_rxSync2 <= r_rxSync1;
    end
  end

  assign w_rxLine = r_rxSync2;

  // ---------------------------------------------------------------------------
  // Receiver FSM. The start bit is confirmed half a bit after the falling
  // edge, which puts every later sample near the middle of its bit.
  // A low stop bit parks the FSM until the line returns high so the tail of
  // a broken frame is not mistaken for a new start bit.
  // ---------------------------------------------------------------------------
  rxState_t          r_rxState, w_rxStateNext;
  logic [TCNT_W-1:0] r_rxTickCnt, w_rxTickCntNext;
  logic [2:0]        r_rxBitIdx, w_rxBitIdxNext;
  logic [7:0]        r_rxShift, w_rxShiftNext;
  logic [7:0]        r_rxData, w_rxDataNext;
  logic              r_rxDone, w_rxDoneNext;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rxState   <= RX_IDLE;
      r_rxTickCnt <= '0;
      r_rxBitIdx  <= '0;
      r_rxShift   <= '0;
      r_rxData    <= '0;
      r_rxDone    <= 1'b0;
    end else begin
      r_rxState   <= w_rxStateNext;
      r_rxTickCnt <= w_rxTickCntNext;
      r_rxBitIdx  <= w_rxBitIdxNext;
      r_rxShift   <= w_rxShiftNext;
      r_rxData    <= w_rxDataNext;
      r_rxDone    <= w_rxDoneNext;
    end
  end

  always_comb begin
    w_rxStateNext   = r_rxState;
    w_rxTickCntNext = r_rxTickCnt;
    w_rxBitIdxNext  = r_rxBitIdx;
    w_rxShiftNext   = r_rxShift;
    w_rxDataNext    = r_rxData;
    w_rxDoneNext    = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        if (rx_enable_in && !w_rxLine) begin
          w_rxStateNext   = RX_START;
          w_rxTickCntNext = '0;
        end
      end
      RX_START: begin
        if (r_tick) begin
          if (r_rxTickCnt == HALF_LAST) begin
            w_rxTickCntNext = '0;
            w_rxBitIdxNext  = '0;
            w_rxStateNext   = w_rxLine ? RX_IDLE : RX_DATA;
          end else begin
            w_rxTickCntNext = r_rxTickCnt + TCNT_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (r_tick) begin
          if (r_rxTickCnt == BIT_LAST) begin
            w_rxTickCntNext = '0;
            w_rxShiftNext   = {w_rxLine, r_rxShift[7:1]};
            if (r_rxBitIdx == 3'd7) begin
              w_rxStateNext = RX_STOP;
            end else begin
              w_rxBitIdxNext = r_rxBitIdx + 3'd1;
            end
          end else begin
            w_rxTickCntNext = r_rxTickCnt + TCNT_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (r_tick) begin
          if (r_rxTickCnt == BIT_LAST) begin
            w_rxTickCntNext = '0;
            if (w_rxLine) begin
              w_rxDataNext  = r_rxShift;
              w_rxDoneNext  = 1'b1;
              w_rxStateNext = RX_IDLE;
            end else begin
              w_rxStateNext = RX_WAIT_IDLE;
            end
          end else begin
            w_rxTickCntNext = r_rxTickCnt + TCNT_W'(1);
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (w_rxLine) begin
          w_rxStateNext = RX_IDLE;
        end
      end
      default: begin
        w_rxStateNext = RX_IDLE;
      end
    endcase
  end

  assign rx_data_out = r_rxData;
  assign rx_done_out = r_rxDone;

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_transceiver
//
// Drives the UART at its default parameters (54 clocks per tick, 864 clocks
// per bit). Loopback frames come from a vector table; glitch, framing-error
// and mid-frame reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_transceiver;

  localparam int BIT_CLKS  = 864;
  localparam int HALF_BIT  = 432;
  localparam int TICK_CLKS = 54;
  localparam int BUSY_MIN  = 8587;
  localparam int BUSY_MAX  = 8640;

  typedef struct {
    logic [7:0] txByte;
    logic       injectEn;
    logic [7:0] injectByte;
    logic [7:0] expRx;
  } vector_t;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       tick;
  logic [7:0] txData = 8'h00;
  logic       txEnable = 1'b0;
  logic       txLine;
  logic       txBusy;
  logic       txDone;
  logic       rxLineTb = 1'b1;
  logic       loopback = 1'b1;
  logic       rxLine;
  logic       rxEnable = 1'b1;
  logic [7:0] rxData;
  logic       rxDone;

  int checkCount = 0;
  int passCount = 0;
  int txDoneSeen = 0;
  int rxDoneSeen = 0;
  int busyCycles = 0;

  vector_t    vectors[3];
  vector_t    lateVec;
  logic [9:0] bitsSeen;
  int         txDones;
  int         rxDones;
  int         busyLen;
  int         txStart;
  int         rxStart;
  int         n;

  assign rxLine = loopback ? txLine : rxLineTb;

  always #5 clock = ~clock;

  uart_transceiver dut (
    .clk_in       (clock),
    .rst_in       (resetN),
    .tick_out     (tick),
    .tx_data_in   (txData),
    .tx_enable_in (txEnable),
    .tx_out       (txLine),
    .tx_busy_out  (txBusy),
    .tx_done_out  (txDone),
    .rx_in        (rxLine),
    .rx_enable_in (rxEnable),
    .rx_data_out  (rxData),
    .rx_done_out  (rxDone)
  );

  // Pulse and busy monitors sample on the falling edge, away from updates
  always @(negedge clock) begin
    if (txDone) txDoneSeen++;
    if (rxDone) rxDoneSeen++;
    if (txBusy) busyCycles++;
  end

  // Expected line sequence: start bit, data LSB first, stop bit
  function automatic logic [9:0] frameBits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checkCount++;
    if (actual >= lo && actual <= hi) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  // Sends one frame in loopback, sampling tx_out mid-bit relative to the
  // clock edge that accepted the enable, then waits (bounded) for done.
  task automatic applyStimulus(input vector_t v, output logic [9:0] bits,
                               output int txCnt, output int rxCnt, output int busyCnt);
    int txS, rxS, busyS;
    bits  = '0;
    txS   = txDoneSeen;
    rxS   = rxDoneSeen;
    busyS = busyCycles;
    @(negedge clock);
    txData   = v.txByte;
    txEnable = 1'b1;
    @(posedge clock);
    #1;
    txEnable = 1'b0;
    for (int c = 1; c <= HALF_BIT + 9 * BIT_CLKS; c++) begin
      @(posedge clock);
      #1;
      if (v.injectEn && c == 2000) begin
        txData   = v.injectByte;
        txEnable = 1'b1;
      end else begin
        txEnable = 1'b0;
      end
      if (c >= HALF_BIT && ((c - HALF_BIT) % BIT_CLKS) == 0)
        bits[(c - HALF_BIT) / BIT_CLKS] = txLine;
    end
    for (int c = 0; c < 2000 && txDoneSeen == txS; c++) @(posedge clock);
    repeat (200) @(posedge clock);
    #1;
    txCnt   = txDoneSeen - txS;
    rxCnt   = rxDoneSeen - rxS;
    busyCnt = busyCycles - busyS;
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      rxLineTb = f[k];
      repeat (BIT_CLKS - 1) @(negedge clock);
    end
    @(negedge clock);
    rxLineTb = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input vector_t v);
    checkOutput({tag, ".txBits"}, 32'(bitsSeen), 32'(frameBits(v.txByte)));
    checkOutput({tag, ".txDoneCount"}, 32'(txDones), 32'd1);
    checkOutput({tag, ".rxDoneCount"}, 32'(rxDones), 32'd1);
    checkOutput({tag, ".rxData"}, 32'(rxData), 32'(v.expRx));
    checkRange({tag, ".busyLen"}, busyLen, BUSY_MIN, BUSY_MAX);
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = '{txByte: 8'h93, injectEn: 1'b0, injectByte: 8'h00, expRx: 8'h93};
    vectors[1] = '{txByte: 8'hC3, injectEn: 1'b0, injectByte: 8'h00, expRx: 8'hC3};
    vectors[2] = '{txByte: 8'hAA, injectEn: 1'b1, injectByte: 8'h55, expRx: 8'hAA};
    lateVec    = '{txByte: 8'h3C, injectEn: 1'b0, injectByte: 8'h00, expRx: 8'h3C};

    // Reset values while held in reset
    repeat (5) @(negedge clock);
    checkOutput("rst.tick", 32'(tick), 32'd0);
    checkOutput("rst.txOut", 32'(txLine), 32'd1);
    checkOutput("rst.txBusy", 32'(txBusy), 32'd0);
    checkOutput("rst.txDone", 32'(txDone), 32'd0);
    checkOutput("rst.rxData", 32'(rxData), 32'd0);
    checkOutput("rst.rxDone", 32'(rxDone), 32'd0);

    // Tick timing after release
    @(negedge clock);
    resetN = 1'b1;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      n++;
      if (tick) break;
    end
    checkOutput("tick.first", 32'(n), 32'(TICK_CLKS));
    @(posedge clock);
    #1;
    checkOutput("tick.width", 32'(tick), 32'd0);
    n = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      n++;
      if (tick) break;
    end
    checkOutput("tick.period", 32'(n), 32'(TICK_CLKS));

    repeat (1000) @(posedge clock);

    // Table-driven loopback frames
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vectors[i], bitsSeen, txDones, rxDones, busyLen);
      checkFrame($sformatf("vec%0d", i), vectors[i]);
      repeat (1000) @(posedge clock);
    end

    // Short low pulse on the line: rejected as a glitch
    loopback = 1'b0;
    rxStart  = rxDoneSeen;
    @(negedge clock);
    rxLineTb = 1'b0;
    repeat (3 * TICK_CLKS) @(negedge clock);
    rxLineTb = 1'b1;
    repeat (2000) @(negedge clock);
    checkOutput("glitch.rxDoneCount", 32'(rxDoneSeen - rxStart), 32'd0);
    checkOutput("glitch.rxData", 32'(rxData), 32'hAA);

    // Frame with a low stop bit: discarded
    rxStart = rxDoneSeen;
    driveFrame(8'h5A, 1'b0);
    repeat (2000) @(negedge clock);
    checkOutput("framing.rxDoneCount", 32'(rxDoneSeen - rxStart), 32'd0);
    checkOutput("framing.rxData", 32'(rxData), 32'hAA);

    // Receiver recovers for a valid frame
    loopback = 1'b1;
    applyStimulus(lateVec, bitsSeen, txDones, rxDones, busyLen);
    checkFrame("late", lateVec);
    repeat (1000) @(posedge clock);

    // Reset asserted mid-frame
    txStart = txDoneSeen;
    rxStart = rxDoneSeen;
    @(negedge clock);
    txData   = 8'hF0;
    txEnable = 1'b1;
    @(negedge clock);
    txEnable = 1'b0;
    repeat (3000) @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOutput("midrst.txOut", 32'(txLine), 32'd1);
    checkOutput("midrst.txBusy", 32'(txBusy), 32'd0);
    checkOutput("midrst.tick", 32'(tick), 32'd0);
    checkOutput("midrst.rxData", 32'(rxData), 32'd0);
    checkOutput("midrst.txDone", 32'(txDone), 32'd0);
    checkOutput("midrst.rxDone", 32'(rxDone), 32'd0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    repeat (7000) @(negedge clock);
    checkOutput("midrst.txDoneCount", 32'(txDoneSeen - txStart), 32'd0);
    checkOutput("midrst.rxDoneCount", 32'(rxDoneSeen - rxStart), 32'd0);
    checkOutput("midrst.busyAfter", 32'(txBusy), 32'd0);
    checkOutput("midrst.rxDataAfter", 32'(rxData), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
